// File: rtl/dma_copy_engine.sv
// dma_copy_engine: word-granular SRAM-to-SRAM copier on the shared DMA port.
// Reads one word, writes it, repeats; after BURST_MAX words it drops dma_req
// for YIELD_CYCLES cycles so the stalled CPU can run. Ends with a done pulse.
module dma_copy_engine #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     LEN_W        = 16,
    parameter logic [XLEN-1:0] ADDR_LIMIT   = 32'h0001_0000,
    parameter int unsigned     BURST_MAX    = 16,
    parameter int unsigned     YIELD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [XLEN-1:0]  cmd_src,
    input  logic [XLEN-1:0]  cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
    output logic             busy,
    output logic             done_irq,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    output logic             dma_req,
    output logic [XLEN-1:0]  dma_addr,
    output logic [XLEN-1:0]  dma_wdata,
    output logic             dma_we,
    input  logic [XLEN-1:0]  dma_rdata,
    input  logic             dma_grant
);

    // Bounds check width: address + 4*len can never overflow this.
    localparam int unsigned ChkW   = XLEN + LEN_W + 2;
    localparam int unsigned BurstW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam int unsigned YieldW = (YIELD_CYCLES > 1) ? $clog2(YIELD_CYCLES) : 1;
    localparam logic [BurstW-1:0] BurstLast = BurstW'(BURST_MAX - 1);
    localparam logic [YieldW-1:0] YieldLast = YieldW'(YIELD_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StYield,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0]   src_q, src_d;
    logic [XLEN-1:0]   dst_q, dst_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [LEN_W-1:0]  words_done_q, words_done_d;
    logic [BurstW-1:0] burst_cnt_q, burst_cnt_d;
    logic [YieldW-1:0] yield_cnt_q, yield_cnt_d;
    logic              err_q, err_d;

    logic [ChkW-1:0] src_end;
    logic [ChkW-1:0] dst_end;
    logic [ChkW-1:0] limit_ext;
    logic            cmd_bad;
    logic            cmd_empty;

    assign src_end   = ChkW'(cmd_src) + (ChkW'(cmd_len) << 2);
    assign dst_end   = ChkW'(cmd_dst) + (ChkW'(cmd_len) << 2);
    assign limit_ext = ChkW'(ADDR_LIMIT);
    assign cmd_empty = (cmd_len == '0);
    assign cmd_bad   = (|cmd_src[1:0]) | (|cmd_dst[1:0]) |
                       (src_end > limit_ext) | (dst_end > limit_ext);

    // State register; reset is synchronous so it can cut a transfer mid-access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; abort takes priority over grant in every active state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = (cmd_empty || cmd_bad) ? StDone : StRd;
                end
            end
            StRd: begin
                if (abort) begin
                    state_d = StDone;
                end else if (dma_grant) begin
                    state_d = StWr;
                end
            end
            StWr: begin
                if (abort) begin
                    state_d = StDone;
                end else if (dma_grant) begin
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = StDone;
                    end else if (burst_cnt_q == BurstLast) begin
                        state_d = StYield;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StYield: begin
                if (abort) begin
                    state_d = StDone;
                end else if (yield_cnt_q == YieldLast) begin
                    state_d = StRd;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values: latch command, capture read data, advance pointers.
    always_comb begin
        src_d        = src_q;
        dst_d        = dst_q;
        data_d       = data_q;
        remaining_d  = remaining_q;
        words_done_d = words_done_q;
        burst_cnt_d  = burst_cnt_q;
        yield_cnt_d  = '0;
        err_d        = err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    src_d        = cmd_src;
                    dst_d        = cmd_dst;
                    remaining_d  = cmd_len;
                    words_done_d = '0;
                    burst_cnt_d  = '0;
                    // A zero-length command completes cleanly even if malformed.
                    err_d        = !cmd_empty && cmd_bad;
                end
            end
            StRd: begin
                if (abort) begin
                    err_d = 1'b1;
                end else if (dma_grant) begin
                    data_d = dma_rdata;
                end
            end
            StWr: begin
                // A granted write always completes, even when aborted.
                if (dma_grant) begin
                    src_d        = src_q + XLEN'(4);
                    dst_d        = dst_q + XLEN'(4);
                    remaining_d  = remaining_q - LEN_W'(1);
                    words_done_d = words_done_q + LEN_W'(1);
                    burst_cnt_d  = burst_cnt_q + BurstW'(1);
                end
                if (abort) begin
                    err_d = 1'b1;
                end
            end
            StYield: begin
                burst_cnt_d = '0;
                yield_cnt_d = yield_cnt_q + YieldW'(1);
                if (abort) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_q        <= '0;
            dst_q        <= '0;
            data_q       <= '0;
            remaining_q  <= '0;
            words_done_q <= '0;
            burst_cnt_q  <= '0;
            yield_cnt_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            src_q        <= src_d;
            dst_q        <= dst_d;
            data_q       <= data_d;
            remaining_q  <= remaining_d;
            words_done_q <= words_done_d;
            burst_cnt_q  <= burst_cnt_d;
            yield_cnt_q  <= yield_cnt_d;
            err_q        <= err_d;
        end
    end

    // Outputs decoded from state; bus fields are forced to zero when not requesting.
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done_irq  = 1'b0;
        dma_req   = 1'b0;
        dma_we    = 1'b0;
        dma_addr  = '0;
        dma_wdata = '0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            StRd: begin
                dma_req  = 1'b1;
                dma_addr = src_q;
            end
            StWr: begin
                dma_req   = 1'b1;
                dma_we    = 1'b1;
                dma_addr  = dst_q;
                dma_wdata = data_q;
            end
            StDone: begin
                done_irq = 1'b1;
            end
            default: ;
        endcase
    end

    assign err        = err_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: bench-side SRAM, grant control and a reference
// copy model; each task drives one scenario and checks it inline.
module tb_dma_copy_engine;

    localparam int MemWords = 16384;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_src;
    logic [31:0] cmd_dst;
    logic [15:0] cmd_len;
    logic        abort;
    logic        busy;
    logic        done_irq;
    logic        err;
    logic [15:0] words_done;
    logic        dma_req;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_we;
    logic [31:0] dma_rdata;
    logic        dma_grant;

    logic        grant_ok;
    logic        force_rd;
    logic [31:0] force_val;

    logic [31:0] mem     [0:MemWords-1];
    logic [31:0] ref_mem [0:MemWords-1];

    int errors = 0;
    int checks = 0;

    dma_copy_engine #(
        .XLEN        (32),
        .LEN_W       (16),
        .ADDR_LIMIT  (32'h0001_0000),
        .BURST_MAX   (16),
        .YIELD_CYCLES(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .abort     (abort),
        .busy      (busy),
        .done_irq  (done_irq),
        .err       (err),
        .words_done(words_done),
        .dma_req   (dma_req),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_we    (dma_we),
        .dma_rdata (dma_rdata),
        .dma_grant (dma_grant)
    );

    always #5 clk = ~clk;

    assign dma_grant = dma_req & grant_ok;
    assign dma_rdata = force_rd ? force_val : mem[dma_addr[15:2]];

    always @(posedge clk) begin
        if (dma_req && dma_grant && dma_we) mem[dma_addr[15:2]] <= dma_wdata;
    end

    task automatic snap();
        for (int i = 0; i < MemWords; i++) ref_mem[i] = mem[i];
    endtask

    // Reference copy: strictly ascending word-by-word, so overlap replicates.
    task automatic model_copy(input int si, input int di, input int n);
        for (int i = 0; i < n; i++) ref_mem[di + i] = ref_mem[si + i];
    endtask

    function automatic int mem_diffs();
        int n;
        n = 0;
        for (int i = 0; i < MemWords; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    // Present a command and return #1 after its acceptance edge (cycle 1 is next).
    task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk);
        for (int w = 0; w < 100 && !cmd_ready; w++) @(negedge clk);
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_ready_timeout: cmd_ready=%b want 1", cmd_ready);
        end
        cmd_src   = s;
        cmd_dst   = d;
        cmd_len   = n;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_len   = '0;
        abort     = 1'b0;
        grant_ok  = 1'b1;
        force_rd  = 1'b0;
        force_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done_irq !== 1'b0) begin errors++; $display("FAIL reset_done_irq: got %b want 0", done_irq); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (dma_req !== 1'b0) begin errors++; $display("FAIL reset_dma_req: got %b want 0", dma_req); end
        checks++; if (dma_we !== 1'b0) begin errors++; $display("FAIL reset_dma_we: got %b want 0", dma_we); end
        checks++; if (dma_addr !== 32'h0) begin errors++; $display("FAIL reset_dma_addr: got %h want 0", dma_addr); end
        checks++; if (dma_wdata !== 32'h0) begin errors++; $display("FAIL reset_dma_wdata: got %h want 0", dma_wdata); end
        checks++; if (words_done !== 16'h0) begin errors++; $display("FAIL reset_words_done: got %0d want 0", words_done); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_copy();
        logic        exp_req;
        logic        exp_we;
        logic        exp_done;
        logic [31:0] exp_addr;
        int          nd;
        grant_ok = 1'b1;
        snap();
        model_copy(32'h100 / 4, 32'h200 / 4, 4);
        issue(32'h100, 32'h200, 16'd4);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            #1;
            exp_req  = (c <= 8);
            exp_we   = exp_req && (c % 2 == 0);
            exp_done = (c == 9);
            if (!exp_req) exp_addr = 32'h0;
            else if (exp_we) exp_addr = 32'h200 + 32'(4 * ((c - 2) / 2));
            else exp_addr = 32'h100 + 32'(4 * ((c - 1) / 2));
            checks++;
            if ({dma_req, dma_we, dma_addr} !== {exp_req, exp_we, exp_addr}) begin
                errors++;
                $display("FAIL basic_bus c=%0d: got req=%b we=%b addr=%h want req=%b we=%b addr=%h",
                         c, dma_req, dma_we, dma_addr, exp_req, exp_we, exp_addr);
            end
            checks++;
            if (done_irq !== exp_done) begin
                errors++;
                $display("FAIL basic_done_irq c=%0d: got %b want %b", c, done_irq, exp_done);
            end
            if (c == 9) begin
                checks++; if (words_done !== 16'd4) begin errors++; $display("FAIL basic_words_done: got %0d want 4", words_done); end
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err); end
            end
        end
        nd = mem_diffs();
        checks++; if (nd != 0) begin errors++; $display("FAIL basic_mem: got %0d differing words want 0", nd); end
    endtask

    task automatic test_burst_yield();
        int req_cyc;
        int n_low;
        int low_cyc;
        int done_cyc;
        int nd;
        req_cyc  = 0;
        n_low    = 0;
        low_cyc  = 0;
        done_cyc = 0;
        grant_ok = 1'b1;
        snap();
        model_copy(32'h1000 / 4, 32'h3000 / 4, 20);
        issue(32'h1000, 32'h3000, 16'd20);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            #1;
            if (done_irq) begin
                done_cyc = c;
                break;
            end
            if (dma_req) req_cyc++;
            else begin
                n_low++;
                if (low_cyc == 0) low_cyc = c;
            end
        end
        checks++; if (req_cyc != 40) begin errors++; $display("FAIL burst_req_cycles: got %0d want 40", req_cyc); end
        checks++; if (n_low != 1) begin errors++; $display("FAIL burst_low_cycles: got %0d want 1", n_low); end
        checks++; if (low_cyc != 33) begin errors++; $display("FAIL burst_low_at: got %0d want 33", low_cyc); end
        checks++; if (done_cyc != 42) begin errors++; $display("FAIL burst_done_cycle: got %0d want 42", done_cyc); end
        checks++; if (words_done !== 16'd20) begin errors++; $display("FAIL burst_words_done: got %0d want 20", words_done); end
        nd = mem_diffs();
        checks++; if (nd != 0) begin errors++; $display("FAIL burst_mem: got %0d differing words want 0", nd); end
    endtask

    task automatic test_grant_stall();
        logic [31:0] v;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [15:0] exp_wd;
        int          nd;
        v = $urandom;
        snap();
        ref_mem[32'h800 / 4]     = v;
        ref_mem[32'h800 / 4 + 1] = ref_mem[32'h400 / 4 + 1];
        grant_ok = 1'b0;
        issue(32'h400, 32'h800, 16'd2);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            grant_ok  = (c == 4) || (c >= 7);
            force_rd  = (c <= 4);
            force_val = (c == 4) ? v : $urandom;
            #1;
            exp_we   = (c >= 5 && c <= 7) || (c == 9);
            exp_addr = (c <= 4) ? 32'h400 : (c <= 7) ? 32'h800 : (c == 8) ? 32'h404 : 32'h804;
            exp_wd   = (c <= 7) ? 16'd0 : (c <= 9) ? 16'd1 : 16'd2;
            if (c <= 9) begin
                checks++;
                if ({dma_req, dma_we, dma_addr} !== {1'b1, exp_we, exp_addr}) begin
                    errors++;
                    $display("FAIL stall_bus c=%0d: got req=%b we=%b addr=%h want req=1 we=%b addr=%h",
                             c, dma_req, dma_we, dma_addr, exp_we, exp_addr);
                end
            end
            if (c >= 5 && c <= 7) begin
                checks++;
                if (dma_wdata !== v) begin
                    errors++;
                    $display("FAIL stall_wdata c=%0d: got %h want %h", c, dma_wdata, v);
                end
            end
            checks++;
            if (words_done !== exp_wd) begin
                errors++;
                $display("FAIL stall_words_done c=%0d: got %0d want %0d", c, words_done, exp_wd);
            end
            if (c == 10) begin
                checks++; if (done_irq !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", done_irq); end
            end
        end
        force_rd = 1'b0;
        grant_ok = 1'b1;
        nd = mem_diffs();
        checks++; if (nd != 0) begin errors++; $display("FAIL stall_mem: got %0d differing words want 0", nd); end
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
    } cmd_t;

    task automatic test_bad_cmds();
        cmd_t        tbl [8];
        logic        exp_err;
        logic        req_seen;
        longint unsigned se;
        longint unsigned de;
        tbl[0] = '{32'h0000_0102, 32'h0000_0200, 16'd2};
        tbl[1] = '{32'h0000_0100, 32'h0000_0203, 16'd2};
        tbl[2] = '{32'h0000_0100, 32'h0000_0200, 16'd0};
        tbl[3] = '{32'h0000_FFF0, 32'h0000_0000, 16'd8};
        tbl[4] = '{32'h0000_0000, 32'h0000_FFF4, 16'd4};
        tbl[5] = '{32'hFFFF_FFFC, 32'h0000_0000, 16'd1};
        tbl[6] = '{32'h0000_0000, 32'hFFFF_FFF0, 16'd4};
        tbl[7] = '{32'h0000_0102, 32'h0000_0001, 16'd0};
        grant_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            se = 64'(tbl[k].src) + 64'(tbl[k].len) * 4;
            de = 64'(tbl[k].dst) + 64'(tbl[k].len) * 4;
            exp_err = (tbl[k].len != 0) &&
                      ((tbl[k].src % 4 != 0) || (tbl[k].dst % 4 != 0) ||
                       (se > 64'h1_0000) || (de > 64'h1_0000));
            req_seen = 1'b0;
            issue(tbl[k].src, tbl[k].dst, tbl[k].len);
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                #1;
                if (dma_req) req_seen = 1'b1;
                checks++;
                if (done_irq !== (c == 1)) begin
                    errors++;
                    $display("FAIL bad_done k=%0d c=%0d: got %b want %b", k, c, done_irq, (c == 1));
                end
                if (c == 1) begin
                    checks++;
                    if (err !== exp_err) begin
                        errors++;
                        $display("FAIL bad_err k=%0d: got %b want %b", k, err, exp_err);
                    end
                end
            end
            checks++;
            if (req_seen !== 1'b0) begin
                errors++;
                $display("FAIL bad_no_bus k=%0d: got req seen=%b want 0", k, req_seen);
            end
        end
    endtask

    // Bounds error, then a copy ending exactly at the limit clears err.
    task automatic test_err_clear();
        int done_cyc;
        int nd;
        done_cyc = 0;
        grant_ok = 1'b1;
        issue(32'h0000_FFF0, 32'h0, 16'd8);
        @(negedge clk);
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL clear_first_err: got %b want 1", err); end
        snap();
        model_copy(32'hFFE0 / 4, 32'h40 / 4, 8);
        issue(32'h0000_FFE0, 32'h40, 16'd8);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            #1;
            if (c == 1) begin
                checks++;
                if ({err, dma_req} !== 2'b01) begin
                    errors++;
                    $display("FAIL clear_on_accept: got err=%b req=%b want err=0 req=1", err, dma_req);
                end
            end
            if (done_irq) begin
                done_cyc = c;
                break;
            end
        end
        checks++; if (done_cyc != 17) begin errors++; $display("FAIL clear_done_cycle: got %0d want 17", done_cyc); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clear_final_err: got %b want 0", err); end
        nd = mem_diffs();
        checks++; if (nd != 0) begin errors++; $display("FAIL clear_mem: got %0d differing words want 0", nd); end
    endtask

    task automatic test_abort();
        int lens [3];
        int acs  [3];
        int ews  [3];
        int nd;
        int si;
        int di;
        lens = '{6, 4, 20};
        acs  = '{6, 3, 33};
        ews  = '{3, 1, 16};
        grant_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            si = (32'h5000 + k * 32'h400) / 4;
            di = (32'h7000 + k * 32'h400) / 4;
            snap();
            model_copy(si, di, ews[k]);
            issue(32'(si * 4), 32'(di * 4), 16'(lens[k]));
            for (int c = 1; c <= acs[k]; c++) begin
                @(negedge clk);
                abort = (c == acs[k]);
                #1;
            end
            @(negedge clk);
            abort = 1'b0;
            #1;
            checks++;
            if ({done_irq, err, dma_req} !== 3'b110) begin
                errors++;
                $display("FAIL abort_done k=%0d: got done=%b err=%b req=%b want done=1 err=1 req=0",
                         k, done_irq, err, dma_req);
            end
            checks++;
            if (words_done !== 16'(ews[k])) begin
                errors++;
                $display("FAIL abort_words_done k=%0d: got %0d want %0d", k, words_done, ews[k]);
            end
            @(negedge clk);
            #1;
            checks++;
            if ({done_irq, cmd_ready} !== 2'b01) begin
                errors++;
                $display("FAIL abort_idle k=%0d: got done=%b ready=%b want done=0 ready=1",
                         k, done_irq, cmd_ready);
            end
            nd = mem_diffs();
            checks++; if (nd != 0) begin errors++; $display("FAIL abort_mem k=%0d: got %0d differing words want 0", k, nd); end
        end
        // Abort while idle must not start anything.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            abort = 1'b1;
            #1;
            checks++;
            if ({done_irq, cmd_ready, busy} !== 3'b010) begin
                errors++;
                $display("FAIL abort_in_idle: got done=%b ready=%b busy=%b want 0 1 0", done_irq, cmd_ready, busy);
            end
        end
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_rd();
        logic activity;
        activity = 1'b0;
        grant_ok = 1'b0;
        issue(32'h100, 32'h200, 16'd3);
        @(negedge clk);
        #1;
        checks++; if (dma_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req_before: got %b want 1", dma_req); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({dma_req, cmd_ready, done_irq, busy} !== 4'b0100) begin
            errors++;
            $display("FAIL rst_mid_after: got req=%b ready=%b done=%b busy=%b want 0 1 0 0",
                     dma_req, cmd_ready, done_irq, busy);
        end
        rst_n    = 1'b1;
        grant_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (dma_req || done_irq) activity = 1'b1;
        end
        checks++; if (activity !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet: got activity=%b want 0", activity); end
    endtask

    // Random copies (some overlapping) under random grant stalls, back to back.
    task automatic test_random_copies();
        int n;
        int si;
        int di;
        int idx;
        int n_low;
        int done_cyc;
        int ready_busy;
        int nd;
        logic        exp_we;
        logic [31:0] exp_addr;
        for (int t = 0; t < 8; t++) begin
            n  = $urandom_range(1, 40);
            si = $urandom_range(0, MemWords - n - 4);
            di = (t % 3 == 0) ? si + int'($urandom_range(1, 3)) : int'($urandom_range(0, MemWords - n));
            snap();
            model_copy(si, di, n);
            idx = 0;
            n_low = 0;
            done_cyc = 0;
            ready_busy = 0;
            issue(32'(si * 4), 32'(di * 4), 16'(n));
            for (int c = 1; c <= 1000; c++) begin
                @(negedge clk);
                grant_ok = ($urandom_range(0, 3) != 0);
                #1;
                if (done_irq) begin
                    done_cyc = c;
                    break;
                end
                if (cmd_ready) ready_busy++;
                if (!dma_req) n_low++;
                else if (dma_grant) begin
                    exp_we   = (idx % 2 == 1);
                    exp_addr = exp_we ? 32'((di + idx / 2) * 4) : 32'((si + idx / 2) * 4);
                    checks++;
                    if (idx >= 2 * n || {dma_we, dma_addr} !== {exp_we, exp_addr}) begin
                        errors++;
                        $display("FAIL rand_access t=%0d idx=%0d: got we=%b addr=%h want we=%b addr=%h",
                                 t, idx, dma_we, dma_addr, exp_we, exp_addr);
                    end
                    if (exp_we && idx < 2 * n) begin
                        checks++;
                        if (dma_wdata !== ref_mem[di + idx / 2]) begin
                            errors++;
                            $display("FAIL rand_wdata t=%0d idx=%0d: got %h want %h",
                                     t, idx, dma_wdata, ref_mem[di + idx / 2]);
                        end
                    end
                    idx++;
                end
            end
            grant_ok = 1'b1;
            checks++; if (done_cyc == 0) begin errors++; $display("FAIL rand_timeout t=%0d: got no done_irq want done", t); end
            checks++; if (idx != 2 * n) begin errors++; $display("FAIL rand_access_count t=%0d: got %0d want %0d", t, idx, 2 * n); end
            checks++; if (n_low != (n - 1) / 16) begin errors++; $display("FAIL rand_yields t=%0d: got %0d want %0d", t, n_low, (n - 1) / 16); end
            checks++; if (ready_busy != 0) begin errors++; $display("FAIL rand_ready_busy t=%0d: got %0d want 0", t, ready_busy); end
            checks++;
            if ({err, words_done} !== {1'b0, 16'(n)}) begin
                errors++;
                $display("FAIL rand_status t=%0d: got err=%b words=%0d want err=0 words=%0d", t, err, words_done, n);
            end
            nd = mem_diffs();
            checks++; if (nd != 0) begin errors++; $display("FAIL rand_mem t=%0d: got %0d differing words want 0", t, nd); end
        end
    endtask

    initial begin
        for (int i = 0; i < MemWords; i++) mem[i] = $urandom;
        test_reset();
        test_basic_copy();
        test_burst_yield();
        test_grant_stall();
        test_bad_cmds();
        test_err_clear();
        test_abort();
        test_reset_mid_rd();
        test_random_copies();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
